rom_mem_bridge: RTL and testbench
=================================

# rom_mem_bridge

Bridge between the picoRV32 native memory port and the single-port synchronous word memory (rom256/rom512 class: one-cycle registered read, full-word write enable). It decodes a configurable address window, sequences reads and writes against the memory's one-cycle read latency and returns a one-cycle `mem_ready` pulse. Byte-strobe writes are handled by read-modify-write, which can be compiled out.

## Interface
- `ADDR_W`, 8: word-address width of the attached memory; 8 for rom256, 9 for rom512.
- `BASE_ADDR`, 32'h0000_0000: byte base of the window. Bits [ADDR_W+1:0] must be zero.

Ports:
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `mem_valid`  in  1: CPU request valid.
- `mem_ready`  out  1: registered; one-cycle completion pulse.
- `mem_addr`  in  32: CPU byte address.
- `mem_wdata`  in  32: CPU write data.
- `mem_wstrb`  in  4: byte strobes; 0 means read.
- `mem_rdata`  out  32: registered read data.
- `ram_wen`  out  1: registered memory write enable.
- `ram_addr`  out  ADDR_W: registered memory word address.
- `ram_wdata`  out  32: registered memory write data.
- `ram_rdata`  in  32: memory read data, valid one cycle after `ram_addr` is sampled.

## Operation
- Select: `sel = (mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2])`. Requests with `sel=0` are ignored; `mem_ready` stays 0 so another slave can answer.
- Word index: `mem_addr[ADDR_W+1:2]`. Bits [1:0] are ignored.
- FSM states: IDLE, RD, RD2, RMW, RMW2, WR, ACK.
  - IDLE: accepts a request when `mem_valid & sel & !mem_ready`. On accept, latches addr, wdata and wstrb and drives `ram_addr`.
    - `wstrb==0`: go to RD.
    - `wstrb==4'hF`: set `ram_wen=1` and `ram_wdata=mem_wdata`; go to WR.
    - Any other nonzero value: go to RMW, or handle as full write (see Configuration).
  - RD: the memory samples the address; go to RD2.
  - RD2: `mem_rdata <= ram_rdata`, `mem_ready <= 1`; go to ACK.
  - WR: `ram_wen <= 0`, `mem_ready <= 1`; go to ACK.
  - RMW: the memory samples the address; go to RMW2.
  - RMW2: builds the merged word from `ram_rdata`, taking each byte i from wdata where `wstrb[i]=1`. Sets `ram_wdata` to the merged word and `ram_wen <= 1`; go to WR.
  - ACK: `mem_ready <= 0`; go to IDLE.
- `mem_rdata` updates only on reads and holds its value across writes.
- Once accepted, a request always completes, even if `mem_valid` drops.
- `mem_addr` is not re-sampled after accept.

## Timing
- Cycle numbering: cycle k is the interval after edge k. `mem_valid` is first high in cycle 0.
- Read: `ram_addr` is valid in cycle 1. Data and `mem_ready` are high in cycle 3. Latency 3.
- Full write: `ram_wen` is high in cycle 1 only. `mem_ready` is high in cycle 2. Latency 2.
- Partial write (RMW): read address in cycle 1; `ram_wen` high with the merged word in cycle 3; `mem_ready` in cycle 4. Latency 4.
- `mem_ready` is always exactly one cycle wide.
- The earliest next accept is the cycle after `mem_ready`. Back-to-back reads give one transaction every 4 cycles.
- `ram_wen` is never high for more than one consecutive cycle.
- Reset values: all outputs 0, state IDLE.
- Reset mid-transaction:
  - All outputs clear immediately and no `mem_ready` is issued.
  - A write whose `ram_wen` edge has already occurred stays committed.
  - An RMW interrupted before RMW2 leaves memory unmodified.

## Configuration
- `ROM_BRIDGE_RMW_EN` defined:
  - Partial strobes use the RMW path, latency 4.
  - Unstrobed bytes are preserved.
- Not defined:
  - RMW and RMW2 are not built.
  - Any nonzero strobe writes the full `mem_wdata` word via the WR path, latency 2.
  - Unstrobed bytes are overwritten.

## Test plan
- Memory preloaded `mem[5]=32'haabbccdd`. Read `mem_addr=32'h14` -> `mem_rdata=32'haabbccdd` with `mem_ready` in cycle 3. `ram_wen` stays 0 throughout.
- Write `mem_addr=32'h20`, `wdata=32'h12345678`, `wstrb=4'hF` -> `ram_wen` for one cycle with `ram_addr=8`. `mem_ready` in cycle 2. A subsequent read returns `32'h12345678`.
- With RMW_EN, `mem[3]=32'haabbccdd`: write `wdata=32'h11223344`, `wstrb=4'b0101` to `32'hC` -> memory becomes `32'haa22cc44`, `mem_ready` in cycle 4. Without RMW_EN the same write makes it `32'h11223344` with `mem_ready` in cycle 2.
- `BASE_ADDR=32'h0001_0000`, `ADDR_W=8`. Request at `32'h0000_0010` -> no `mem_ready` within 10 cycles, no `ram_wen`. Request at `32'h0001_0010` -> serviced normally.
- Assert `resetn=0` in cycle 1 of a full write (`ram_wen` high) -> all outputs 0 and state IDLE. After release the next read completes with normal latency.
- Hold `mem_valid` high for 2 cycles after `mem_ready` with the same read -> exactly one extra transaction is accepted, the cycle after `mem_ready`, and no duplicate `ram_wen` occurs.

Source files
------------

// File: rtl/rom_mem_bridge.sv
// rom_mem_bridge: connects the picoRV32 native memory port to a single-port
// synchronous word memory (one-cycle registered read, full-word write enable).
// Decodes an address window, sequences reads/writes around the memory's read
// latency and returns a one-cycle mem_ready pulse.
// Optional feature macro: ROM_BRIDGE_RMW_EN -- when defined, partial byte-strobe
// writes are merged with the stored word by read-modify-write; when undefined,
// any nonzero strobe writes the whole mem_wdata word.

module rom_mem_bridge #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD2,
`ifdef ROM_BRIDGE_RMW_EN
    RMW,
    RMW2,
`endif
    WR,
    ACK
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sel;
  logic                accept;
  logic [ADDR_W-1:0]   word_idx;
  logic                unused_addr_bits;

  logic                mem_ready_nxt;
  logic [31:0]         mem_rdata_nxt;
  logic                ram_wen_nxt;
  logic [ADDR_W-1:0]   ram_addr_nxt;
  logic [31:0]         ram_wdata_nxt;

`ifdef ROM_BRIDGE_RMW_EN
  logic [31:0]         wdata_q;
  logic [31:0]         wdata_q_nxt;
  logic [3:0]          wstrb_q;
  logic [3:0]          wstrb_q_nxt;
  logic [31:0]         merged;
`endif

  // Window decode is on the bits above the word index; the byte offset is ignored.
  assign sel              = (mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign accept           = mem_valid & sel & ~mem_ready;
  assign word_idx         = mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^mem_addr[1:0];

`ifdef ROM_BRIDGE_RMW_EN
  // Merge strobed bytes of the latched write data over the word just read back.
  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
`endif

  // State and registered outputs; async reset drops everything so no ready is issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef ROM_BRIDGE_RMW_EN
      wdata_q   <= '0;
      wstrb_q   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      mem_ready <= mem_ready_nxt;
      mem_rdata <= mem_rdata_nxt;
      ram_wen   <= ram_wen_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
`ifdef ROM_BRIDGE_RMW_EN
      wdata_q   <= wdata_q_nxt;
      wstrb_q   <= wstrb_q_nxt;
`endif
    end
  end

  // Next-state: reads and RMW wait one cycle for the memory's registered read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_wstrb == 4'h0)      state_nxt = RD;
          else if (mem_wstrb == 4'hF) state_nxt = WR;
          else begin
`ifdef ROM_BRIDGE_RMW_EN
            state_nxt = RMW;
`else
            state_nxt = WR;
`endif
          end
        end
      end
      RD:      state_nxt = RD2;
      RD2:     state_nxt = ACK;
`ifdef ROM_BRIDGE_RMW_EN
      RMW:     state_nxt = RMW2;
      RMW2:    state_nxt = WR;
`endif
      WR:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of registered outputs; everything holds unless the state updates it.
  always_comb begin
    mem_ready_nxt = mem_ready;
    mem_rdata_nxt = mem_rdata;
    ram_wen_nxt   = ram_wen;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
`ifdef ROM_BRIDGE_RMW_EN
    wdata_q_nxt   = wdata_q;
    wstrb_q_nxt   = wstrb_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          ram_addr_nxt = word_idx;
          if (mem_wstrb == 4'hF) begin
            ram_wen_nxt   = 1'b1;
            ram_wdata_nxt = mem_wdata;
          end else if (mem_wstrb != 4'h0) begin
`ifdef ROM_BRIDGE_RMW_EN
            wdata_q_nxt = mem_wdata;
            wstrb_q_nxt = mem_wstrb;
`else
            ram_wen_nxt   = 1'b1;
            ram_wdata_nxt = mem_wdata;
`endif
          end
        end
      end
      RD2: begin
        mem_rdata_nxt = ram_rdata;
        mem_ready_nxt = 1'b1;
      end
`ifdef ROM_BRIDGE_RMW_EN
      RMW2: begin
        ram_wdata_nxt = merged;
        ram_wen_nxt   = 1'b1;
      end
`endif
      WR: begin
        ram_wen_nxt   = 1'b0;
        mem_ready_nxt = 1'b1;
      end
      ACK: begin
        mem_ready_nxt = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rom_mem_bridge.sv
// tb_rom_mem_bridge: two bridges share one CPU bus, dut0 windowed at 0x0 and
// dut1 at 0x0001_0000, each with its own synchronous word memory model.
// Expected values follow ROM_BRIDGE_RMW_EN when it is defined for the build.

module tb_rom_mem_bridge;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        mem_ready0, mem_ready1;
  logic [31:0] mem_rdata0, mem_rdata1;
  logic        ram_wen0, ram_wen1;
  logic [7:0]  ram_addr0, ram_addr1;
  logic [31:0] ram_wdata0, ram_wdata1;
  logic [31:0] ram_rdata0, ram_rdata1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic        ldEn0, ldEn1;
  logic [7:0]  ldAddr;
  logic [31:0] ldData;

  int compared = 0;
  int mismatched = 0;
  int readyCnt0 = 0;

  int          rdyFirst, rdySecond, rdyCount, wenCount, wenFirst;
  logic [7:0]  wenAddr, addrC1;
  logic [31:0] wenData, rdataFirst;
  int          rc;

  rom_mem_bridge #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready0),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata0), .ram_wen(ram_wen0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  rom_mem_bridge #(.ADDR_W(8), .BASE_ADDR(32'h0001_0000)) dut1 (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata1), .ram_wen(ram_wen1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: one-cycle registered read, full-word write, tb preload port.
  always @(posedge clk) begin
    if (ldEn0) mem0[ldAddr] <= ldData;
    else if (ram_wen0) mem0[ram_addr0] <= ram_wdata0;
    ram_rdata0 <= mem0[ram_addr0];
  end

  always @(posedge clk) begin
    if (ldEn1) mem1[ldAddr] <= ldData;
    else if (ram_wen1) mem1[ram_addr1] <= ram_wdata1;
    ram_rdata1 <= mem1[ram_addr1];
  end

  // Running count of dut0 completion pulses, used to spot stray readies.
  always @(negedge clk) begin
    if (mem_ready0) readyCnt0 <= readyCnt0 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic preload(input bit which, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ldAddr = a;
    ldData = d;
    if (which) ldEn1 = 1'b1;
    else ldEn0 = 1'b1;
    @(negedge clk);
    ldEn0 = 1'b0;
    ldEn1 = 1'b0;
  endtask

  // Drives one request from cycle 0 and records per-cycle observations of the chosen dut.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input bit obs,
                               input int holdAfter, input int maxC);
    int   dropAt;
    logic rdy;
    logic wen;
    rdyFirst = -1; rdySecond = -1; rdyCount = 0; wenCount = 0; wenFirst = -1;
    wenAddr = '0; wenData = '0; rdataFirst = '0; addrC1 = '0; dropAt = -1;
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_valid = 1'b1;
    for (int c = 1; c <= maxC; c++) begin
      @(negedge clk);
      rdy = obs ? mem_ready1 : mem_ready0;
      wen = obs ? ram_wen1 : ram_wen0;
      if (c == 1) addrC1 = obs ? ram_addr1 : ram_addr0;
      if (wen) begin
        wenCount++;
        if (wenFirst < 0) begin
          wenFirst = c;
          wenAddr  = obs ? ram_addr1 : ram_addr0;
          wenData  = obs ? ram_wdata1 : ram_wdata0;
        end
      end
      if (rdy) begin
        rdyCount++;
        if (rdyFirst < 0) begin
          rdyFirst   = c;
          rdataFirst = obs ? mem_rdata1 : mem_rdata0;
          dropAt     = (holdAfter == 0) ? c : c + holdAfter + 1;
        end else if (rdySecond < 0) begin
          rdySecond = c;
        end
      end
      if (dropAt >= 0 && c >= dropAt) mem_valid = 1'b0;
      if (holdAfter == 0 && rdyFirst >= 0) break;
    end
    mem_valid = 1'b0;
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    ldEn0 = 1'b0; ldEn1 = 1'b0; ldAddr = '0; ldData = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_mem_ready", {31'b0, mem_ready0}, 32'h0);
    checkOutput("reset_mem_rdata", mem_rdata0, 32'h0);
    checkOutput("reset_ram_wen", {31'b0, ram_wen0}, 32'h0);
    checkOutput("reset_ram_addr", {24'b0, ram_addr0}, 32'h0);
    checkOutput("reset_ram_wdata", ram_wdata0, 32'h0);
    resetn = 1'b1;

    preload(1'b0, 8'd5, 32'haabbccdd);
    preload(1'b0, 8'd3, 32'haabbccdd);
    preload(1'b0, 8'd9, 32'h55555555);

    $display("[TB] read 0x14");
    applyStimulus(32'h14, 32'h0, 4'h0, 1'b0, 0, 10);
    checkOutput("rd_ready_cycle", rdyFirst, 3);
    checkOutput("rd_data", rdataFirst, 32'haabbccdd);
    checkOutput("rd_addr_cycle1", {24'b0, addrC1}, 32'd5);
    checkOutput("rd_no_wen", wenCount, 0);

    $display("[TB] full write 0x20");
    applyStimulus(32'h20, 32'h12345678, 4'hF, 1'b0, 0, 10);
    checkOutput("wr_ready_cycle", rdyFirst, 2);
    checkOutput("wr_wen_count", wenCount, 1);
    checkOutput("wr_wen_cycle", wenFirst, 1);
    checkOutput("wr_wen_addr", {24'b0, wenAddr}, 32'd8);
    checkOutput("wr_wen_data", wenData, 32'h12345678);
    checkOutput("wr_mem", mem0[8], 32'h12345678);
    checkOutput("wr_rdata_hold", mem_rdata0, 32'haabbccdd);

    applyStimulus(32'h20, 32'h0, 4'h0, 1'b0, 0, 10);
    checkOutput("rdback_ready_cycle", rdyFirst, 3);
    checkOutput("rdback_data", rdataFirst, 32'h12345678);

    $display("[TB] partial write 0xC strobe 0101");
    applyStimulus(32'hC, 32'h11223344, 4'b0101, 1'b0, 0, 10);
`ifdef ROM_BRIDGE_RMW_EN
    checkOutput("pw_ready_cycle", rdyFirst, 4);
    checkOutput("pw_wen_cycle", wenFirst, 3);
    checkOutput("pw_wen_data", wenData, 32'haa22cc44);
    checkOutput("pw_mem", mem0[3], 32'haa22cc44);
`else
    checkOutput("pw_ready_cycle", rdyFirst, 2);
    checkOutput("pw_wen_cycle", wenFirst, 1);
    checkOutput("pw_wen_data", wenData, 32'h11223344);
    checkOutput("pw_mem", mem0[3], 32'h11223344);
`endif
    checkOutput("pw_wen_count", wenCount, 1);
    applyStimulus(32'hC, 32'h0, 4'h0, 1'b0, 0, 10);
`ifdef ROM_BRIDGE_RMW_EN
    checkOutput("pw_rdback", rdataFirst, 32'haa22cc44);
`else
    checkOutput("pw_rdback", rdataFirst, 32'h11223344);
`endif

    $display("[TB] address window");
    applyStimulus(32'h0000_0010, 32'h0, 4'h0, 1'b1, 0, 10);
    checkOutput("win_out_no_ready", rdyCount, 0);
    checkOutput("win_out_no_wen", wenCount, 0);
    repeat (8) @(negedge clk);
    rc = readyCnt0;
    applyStimulus(32'h0001_0010, 32'hcafe0001, 4'hF, 1'b1, 0, 10);
    checkOutput("win_in_ready_cycle", rdyFirst, 2);
    checkOutput("win_in_wen_addr", {24'b0, wenAddr}, 32'd4);
    checkOutput("win_in_mem", mem1[4], 32'hcafe0001);
    applyStimulus(32'h0001_0010, 32'h0, 4'h0, 1'b1, 0, 10);
    checkOutput("win_in_rdback", rdataFirst, 32'hcafe0001);
    repeat (2) @(negedge clk);
    checkOutput("win_other_silent", readyCnt0 - rc, 0);

    $display("[TB] reset during full write");
    @(negedge clk);
    mem_addr = 32'h24; mem_wdata = 32'hdeadbeef; mem_wstrb = 4'hF; mem_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_wen_before", {31'b0, ram_wen0}, 32'h1);
    rc = readyCnt0;
    resetn = 1'b0;
    #1;
    checkOutput("rst_mem_ready", {31'b0, mem_ready0}, 32'h0);
    checkOutput("rst_ram_wen", {31'b0, ram_wen0}, 32'h0);
    checkOutput("rst_ram_addr", {24'b0, ram_addr0}, 32'h0);
    checkOutput("rst_ram_wdata", ram_wdata0, 32'h0);
    checkOutput("rst_mem_rdata", mem_rdata0, 32'h0);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_no_ready", readyCnt0 - rc, 0);
    checkOutput("rst_mem_kept", mem0[9], 32'h55555555);
    applyStimulus(32'h14, 32'h0, 4'h0, 1'b0, 0, 10);
    checkOutput("rst_rd_ready_cycle", rdyFirst, 3);
    checkOutput("rst_rd_data", rdataFirst, 32'haabbccdd);

    $display("[TB] mem_valid held after ready");
    applyStimulus(32'h14, 32'h0, 4'h0, 1'b0, 2, 12);
    checkOutput("hold_rd_count", rdyCount, 2);
    checkOutput("hold_rd_first", rdyFirst, 3);
    checkOutput("hold_rd_second", rdySecond, 7);
    checkOutput("hold_rd_no_wen", wenCount, 0);
    applyStimulus(32'h28, 32'h0f0f0f0f, 4'hF, 1'b0, 2, 12);
    checkOutput("hold_wr_count", rdyCount, 2);
    checkOutput("hold_wr_second", rdySecond, 5);
    checkOutput("hold_wr_wen_count", wenCount, 2);
    checkOutput("hold_wr_mem", mem0[10], 32'h0f0f0f0f);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
